axi_frame_wr_arbiter: RTL

AXI_FRAME_WR_ARBITER -- requirements
Module: axi_frame_wr_arbiter

---
 rtl/video_axi_pkg.sv | 33 +++
 rtl/frame_addr_gen.sv | 85 ++++++++
 rtl/axi_frame_wr_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/video_axi_pkg.sv
// rtl/video_axi_pkg.sv - shared FSM state type and frame/burst geometry for the video AXI writer
package video_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_AW,
        ST_W,
        ST_B
    } arb_state_t;

    function automatic logic [31:0] beats_per_frame(input int hdisp, input int vdisp);
        return 32'(hdisp * vdisp / 2);
    endfunction

    function automatic logic [31:0] bursts_per_frame(input int hdisp, input int vdisp, input int burst_len);
        return beats_per_frame(hdisp, vdisp) / 32'(burst_len);
    endfunction

    function automatic logic [31:0] frame_bytes(input int hdisp, input int vdisp, input int data_width);
        return beats_per_frame(hdisp, vdisp) * 32'(data_width / 8);
    endfunction

    function automatic logic [31:0] burst_bytes(input int burst_len, input int data_width);
        return 32'(burst_len * data_width / 8);
    endfunction

    localparam logic [31:0] BEATS_PER_FRAME  = beats_per_frame(640, 480);
    localparam logic [31:0] BURSTS_PER_FRAME = bursts_per_frame(640, 480, 16);
    localparam logic [31:0] FRAME_BYTES      = frame_bytes(640, 480, 64);
    localparam logic [31:0] BURST_BYTES      = burst_bytes(16, 64);

endpackage

// File: rtl/frame_addr_gen.sv
// rtl/frame_addr_gen.sv - per-channel frame tracking and burst address generation (PINGPONG_EN selects double buffering)
module frame_addr_gen
    import video_axi_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter int          IMG_HDISP  = 640,
    parameter int          IMG_VDISP  = 480,
    parameter int          BURST_LEN  = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [9:0]  fifo_cnt,
    input  logic        b_done,
    output logic        req,
    output logic [31:0] burst_addr,
    output logic        frame_done
);

    localparam logic [31:0] BURSTS  = bursts_per_frame(IMG_HDISP, IMG_VDISP, BURST_LEN);
    localparam logic [31:0] BBYTES  = burst_bytes(BURST_LEN, DATA_WIDTH);
    localparam logic [9:0]  CNT_MIN = 10'(BURST_LEN);

    logic        active;
    logic        pending;
    logic [31:0] burst_idx;
    logic [31:0] buf_off;
    logic        restart;

    // A restart is only ever applied on a B handshake so a burst in flight is never cut short
    assign restart    = b_done && (pending || frame_start);
    assign req        = active && (fifo_cnt >= CNT_MIN);
    assign burst_addr = BASE_ADDR + buf_off + burst_idx * BBYTES;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active     <= 1'b0;
            pending    <= 1'b0;
            burst_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!active) begin
                active <= frame_start;
            end else if (b_done) begin
                pending <= 1'b0;
                if (restart) begin
                    burst_idx <= '0;
                end else if (burst_idx == BURSTS - 1) begin
                    burst_idx  <= '0;
                    active     <= 1'b0;
                    frame_done <= 1'b1;
                end else begin
                    burst_idx <= burst_idx + 1;
                end
            end else if (frame_start) begin
                pending <= 1'b1;
            end
        end
    end

`ifdef PINGPONG_EN
    localparam logic [31:0] FBYTES = frame_bytes(IMG_HDISP, IMG_VDISP, DATA_WIDTH);

    logic buf_sel;
    logic wr_buf;

    // buf_sel is the buffer the next frame will use; wr_buf is the one being written now
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_sel <= 1'b0;
            wr_buf  <= 1'b0;
        end else if ((frame_start && !active) || (active && restart)) begin
            wr_buf  <= buf_sel;
            buf_sel <= ~buf_sel;
        end
    end

    assign buf_off = wr_buf ? FBYTES : '0;
`else
    assign buf_off = '0;
`endif

endmodule

// File: rtl/axi_frame_wr_arbiter.sv
// rtl/axi_frame_wr_arbiter.sv - two-channel round-robin AXI frame writer, one burst outstanding (PINGPONG_EN enables double buffering)
module axi_frame_wr_arbiter
    import video_axi_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter int          IMG_HDISP  = 640,
    parameter int          IMG_VDISP  = 480,
    parameter int          BURST_LEN  = 16,
    parameter logic [31:0] CH0_BASE   = 32'h1000_0000,
    parameter logic [31:0] CH1_BASE   = 32'h1038_4000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ch0_frame_start,
    input  logic [9:0]            ch0_fifo_cnt,
    input  logic [DATA_WIDTH-1:0] ch0_rd_data,
    output logic                  ch0_rd_en,
    output logic                  ch0_frame_done,
    input  logic                  ch1_frame_start,
    input  logic [9:0]            ch1_fifo_cnt,
    input  logic [DATA_WIDTH-1:0] ch1_rd_data,
    output logic                  ch1_rd_en,
    output logic                  ch1_frame_done,
    output logic [31:0]           awaddr,
    output logic [7:0]            awlen,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    arb_state_t  state;
    logic        gnt;
    logic        last_gnt;
    logic [7:0]  beat;
    logic        ch0_req;
    logic        ch1_req;
    logic [31:0] ch0_addr;
    logic [31:0] ch1_addr;
    logic        b_hs;
    logic        pick;

    assign b_hs = bready && bvalid;

    frame_addr_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_HDISP  (IMG_HDISP),
        .IMG_VDISP  (IMG_VDISP),
        .BURST_LEN  (BURST_LEN),
        .BASE_ADDR  (CH0_BASE)
    ) u_ch0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (ch0_frame_start),
        .fifo_cnt    (ch0_fifo_cnt),
        .b_done      (b_hs && !gnt),
        .req         (ch0_req),
        .burst_addr  (ch0_addr),
        .frame_done  (ch0_frame_done)
    );

    frame_addr_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_HDISP  (IMG_HDISP),
        .IMG_VDISP  (IMG_VDISP),
        .BURST_LEN  (BURST_LEN),
        .BASE_ADDR  (CH1_BASE)
    ) u_ch1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (ch1_frame_start),
        .fifo_cnt    (ch1_fifo_cnt),
        .b_done      (b_hs && gnt),
        .req         (ch1_req),
        .burst_addr  (ch1_addr),
        .frame_done  (ch1_frame_done)
    );

    // On contention the channel not served last wins; otherwise the sole requester
    assign pick      = (ch0_req && ch1_req) ? ~last_gnt : ch1_req;
    assign wlast     = wvalid && (beat == LAST_BEAT);
    assign wdata     = wvalid ? (gnt ? ch1_rd_data : ch0_rd_data) : '0;
    assign ch0_rd_en = wvalid && wready && !gnt;
    assign ch1_rd_en = wvalid && wready && gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            beat     <= '0;
            awaddr   <= '0;
            awlen    <= '0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ch0_req || ch1_req) state <= ST_ARB;
                end
                ST_ARB: begin
                    if (ch0_req || ch1_req) begin
                        gnt      <= pick;
                        last_gnt <= pick;
                        awaddr   <= pick ? ch1_addr : ch0_addr;
                        awlen    <= LAST_BEAT;
                        awvalid  <= 1'b1;
                        state    <= ST_AW;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        beat    <= '0;
                        state   <= ST_W;
                    end
                end
                ST_W: begin
                    if (wready) begin
                        if (beat == LAST_BEAT) begin
                            wvalid <= 1'b0;
                            bready <= 1'b1;
                            state  <= ST_B;
                        end else begin
                            beat <= beat + 8'd1;
                        end
                    end
                end
                ST_B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
